// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard/redirect requests into the stall sequencer and the
// pipeline-register controls it returns.
interface pipeline_ctrl_if;
    logic        lu_hazard;
    logic        ex_muldiv;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt;

    modport master (
        output lu_hazard, ex_muldiv, branch_taken, mem_req, mem_ack,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, ex_mem_bubble, state_o, stall_cnt
    );

    modport slave (
        input  lu_hazard, ex_muldiv, branch_taken, mem_req, mem_ack,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, ex_mem_bubble, state_o, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > mul/div > branch > load-use.
// Controls are Mealy (same cycle); memory wait freezes every stage until mem_ack.
module pipeline_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    logic pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, ex_mem_bubble;
    logic eval_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        eval_run      = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    state_d      = MEM_WAIT;
                end else begin
                    eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ack) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                end else begin
                    eval_run = 1'b1;
                end
            end
            MULDIV: begin
                if (cnt_q > CNT_W'(1)) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_d         = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Shared by RUN and the ack cycle of MEM_WAIT.
        if (eval_run) begin
            state_d = RUN;
            if (bus.ex_muldiv) begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                cnt_d         = CNT_W'(MULDIV_LAT - 1);
                state_d       = MULDIV;
            end else if (bus.branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.lu_hazard) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;

        // Reset forces every control low without waiting for an edge.
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_bubble = 1'b0;
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.if_id_write   = if_id_write;
    assign bus.id_ex_write   = id_ex_write;
    assign bus.ex_mem_write  = ex_mem_write;
    assign bus.if_id_flush   = if_id_flush;
    assign bus.id_ex_flush   = id_ex_flush;
    assign bus.ex_mem_bubble = ex_mem_bubble;
    assign bus.state_o       = state_q;
    assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It merges the hazard unit's load-use stall, EX-stage taken-branch redirects, multi-cycle mul/div occupancy of EX, and data-memory wait states. From these it drives the pipeline-register write enables, flushes and bubbles. It sits beside hazard_unit and replaces the direct wiring of hazard_unit outputs to the pipeline registers.

Parameters:
MULDIV_LAT, 4, total cycles a mul/div occupies EX; legal range 2..8
CNT_W, 3, width of the mul/div countdown; must hold MULDIV_LAT-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
lu_hazard  in  1  load-use stall request from hazard_unit (its stall output)
ex_muldiv  in  1  valid mul/div instruction in EX
branch_taken  in  1  EX resolved a taken branch or jump (PC redirect)
mem_req  in  1  MEM stage holds a load/store accessing data memory
mem_ack  in  1  data memory completes the access this cycle
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
id_ex_write  out  1  ID/EX register enable
ex_mem_write  out  1  EX/MEM register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  load NOP into ID/EX
ex_mem_bubble  out  1  load NOP into EX/MEM
state_o  out  2  FSM state: RUN=0, MEM_WAIT=1, MULDIV=2
stall_cnt  out  16  count of cycles with pc_write==0; saturates at 16'hFFFF

Behaviour:
- Outputs are combinational from state and inputs (Mealy). state, cnt and stall_cnt are registered.
- While rst=1: state=RUN, cnt=0, stall_cnt=0, all enables/flushes/bubble=0. Reset takes effect immediately, including mid-MEM_WAIT or mid-MULDIV.
- Default outputs ("advance"): all four write enables=1; flushes and bubble=0.
- RUN priority, highest first:
  1. mem_req & !mem_ack: all four enables=0; next state MEM_WAIT. branch_taken, ex_muldiv and lu_hazard are ignored this cycle.
  2. ex_muldiv: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, ex_mem_write=1; cnt<=MULDIV_LAT-1; next state MULDIV.
  3. branch_taken: advance, plus if_id_flush=1 and id_ex_flush=1. Overrides lu_hazard.
  4. lu_hazard: pc_write=if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1.
  5. Otherwise: advance.
- MEM_WAIT:
  - mem_ack=0: all enables=0; stay.
  - mem_ack=1: evaluate RUN priorities 2..5 this same cycle, with the same outputs and next state (MULDIV or RUN).
- MULDIV:
  - cnt>1: same outputs as the RUN entry cycle (freeze front, bubble MEM); cnt<=cnt-1.
  - cnt==1: advance, all flushes/bubble=0; next state RUN.
  - ex_muldiv, branch_taken, lu_hazard and mem_req are ignored. MEM holds a bubble, so mem_req is 0 by construction.
  - EX occupancy is exactly MULDIV_LAT cycles, counting the entry cycle.
- Back-to-back mul/div: the instruction arriving in EX after an exit is evaluated fresh in RUN.
- stall_cnt increments on every non-reset cycle with pc_write==0 and holds at 16'hFFFF.
- state_o encoding 3 is unreachable; if it is ever entered, the FSM returns to RUN on the next cycle.

Test Plan:
- No hazard: all inputs 0 for 3 cycles -> all enables=1, flushes=0, state_o=0, stall_cnt=0.
- Load-use: lu_hazard=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1, stall_cnt=1. Then lu_hazard=1 together with branch_taken=1 -> if_id_flush=id_ex_flush=1, pc_write=1, stall_cnt unchanged.
- Mul/div, MULDIV_LAT=4: ex_muldiv=1 at cycle T -> pc_write=0 and ex_mem_bubble=1 on T..T+2; state_o=2 on T+1..T+2; all advance at T+3; state_o=0 at T+4; stall_cnt=3.
- Memory wait: mem_req=1, mem_ack=0 for 3 cycles then mem_ack=1, with ex_muldiv=1 throughout -> all enables=0 for 3 cycles (state_o=1). On the ack cycle, MULDIV is entered (bubble=1, state_o=2 next cycle).
- Branch during mem wait: branch_taken=1 while in MEM_WAIT with mem_ack=0 -> no flush. On the ack cycle -> if_id_flush=id_ex_flush=1.
- Async reset in MULDIV at cnt=2: rst pulse mid-cycle -> state_o=0, stall_cnt=0, outputs=0 immediately. After release with inputs 0 -> all enables=1 next cycle.
